// File: rtl/cp0_if.sv
// CP0 register-file bus: MTC0/MFC0 access, M-stage exception inputs and architectural outputs.
interface cp0_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        in_delay_i;
  logic [31:0] badaddr_i;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic        timer_int_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, int_i, excepttype_i, pc_i, in_delay_i, badaddr_i,
    input  rdata_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, int_i, excepttype_i, pc_i, in_delay_i, badaddr_i,
    output rdata_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, timer_int_o
  );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: Count/Compare timer, Status/Cause/EPC/BadVAddr and exception entry/ERET.
module cp0_regfile #(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int          COUNT_DIV  = 2
) (
  input  logic  clk,
  input  logic  rst,
  cp0_if.slave  bus
);
  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] EXC_ADEL     = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES     = 32'h0000_0005;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000E;

  logic [31:0] count, compare, status, cause, epc, badVAddr;
  logic [31:0] countNext, compareNext, statusNext, causeNext, epcNext, badVAddrNext;
  logic        timerInt, timerIntNext, tick, countInc;
  logic        isExc, isEret, wrCount, wrCompare, wrStatus, wrCause, wrEpc;
  logic [31:0] statusMerged, causeMerged;

  always_comb begin
    isEret    = (bus.excepttype_i == EXC_ERET);
    isExc     = (bus.excepttype_i != 32'd0) && !isEret;
    wrCount   = bus.we_i && (bus.waddr_i == REG_COUNT);
    wrCompare = bus.we_i && (bus.waddr_i == REG_COMPARE);
    wrStatus  = bus.we_i && (bus.waddr_i == REG_STATUS);
    wrCause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
    wrEpc     = bus.we_i && (bus.waddr_i == REG_EPC);
    countInc  = (COUNT_DIV == 1) ? 1'b1 : tick;
    statusMerged = (status & ~STATUS_WMASK) | (bus.wdata_i & STATUS_WMASK);
    causeMerged  = (cause & ~CAUSE_WMASK) | (bus.wdata_i & CAUSE_WMASK);
  end

  // MTC0 lands first; exception/ERET then overrides only the fields it owns.
  always_comb begin
    countNext    = wrCount ? bus.wdata_i : count + {31'd0, countInc};
    compareNext  = wrCompare ? bus.wdata_i : compare;
    timerIntNext = timerInt;
    if (wrCompare)                            timerIntNext = 1'b0;
    else if (compare != 32'd0 && count == compare) timerIntNext = 1'b1;

    statusNext = wrStatus ? statusMerged : status;
    if (isExc)       statusNext[1] = 1'b1;
    else if (isEret) statusNext[1] = 1'b0;

    causeNext = wrCause ? causeMerged : cause;
    causeNext[15:10] = {bus.int_i[5] | timerInt, bus.int_i[4:0]};
    epcNext      = wrEpc ? bus.wdata_i : epc;
    badVAddrNext = badVAddr;
    if (isExc) begin
      causeNext[6:2] = bus.excepttype_i[4:0];
      // Nested exceptions keep the original return point.
      if (!status[1]) begin
        epcNext       = bus.in_delay_i ? bus.pc_i - 32'd4 : bus.pc_i;
        causeNext[31] = bus.in_delay_i;
      end
      if (bus.excepttype_i == EXC_ADEL || bus.excepttype_i == EXC_ADES)
        badVAddrNext = bus.badaddr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      compare  <= '0;
      status   <= STATUS_RST;
      cause    <= '0;
      epc      <= '0;
      badVAddr <= '0;
      timerInt <= 1'b0;
      tick     <= 1'b0;
    end else begin
      count    <= countNext;
      compare  <= compareNext;
      status   <= statusNext;
      cause    <= causeNext;
      epc      <= epcNext;
      badVAddr <= badVAddrNext;
      timerInt <= timerIntNext;
      tick     <= ~tick;
    end
  end

  // MFC0 read with same-cycle MTC0 bypass for writable registers.
  always_comb begin
    bus.rdata_o = '0;
    if (bus.we_i && bus.waddr_i == bus.raddr_i) begin
      case (bus.raddr_i)
        REG_BADVADDR: bus.rdata_o = badVAddr;
        REG_COUNT:    bus.rdata_o = bus.wdata_i;
        REG_COMPARE:  bus.rdata_o = bus.wdata_i;
        REG_STATUS:   bus.rdata_o = statusMerged;
        REG_CAUSE:    bus.rdata_o = causeMerged;
        REG_EPC:      bus.rdata_o = bus.wdata_i;
        default:      bus.rdata_o = '0;
      endcase
    end else begin
      case (bus.raddr_i)
        REG_BADVADDR: bus.rdata_o = badVAddr;
        REG_COUNT:    bus.rdata_o = count;
        REG_COMPARE:  bus.rdata_o = compare;
        REG_STATUS:   bus.rdata_o = status;
        REG_CAUSE:    bus.rdata_o = cause;
        REG_EPC:      bus.rdata_o = epc;
        default:      bus.rdata_o = '0;
      endcase
    end
  end

  assign bus.count_o     = count;
  assign bus.compare_o   = compare;
  assign bus.status_o    = status;
  assign bus.cause_o     = cause;
  assign bus.epc_o       = epc;
  assign bus.badvaddr_o  = badVAddr;
  assign bus.timer_int_o = timerInt;
endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: hand sequences for timer/reset plus a vector table for exceptions and MTC0/MFC0.
module tb_cp0_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cp0_if bus ();

  cp0_regfile #(.STATUS_RST(32'h0040_0000), .COUNT_DIV(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam int S_RD = 0, S_COUNT = 1, S_COMPARE = 2, S_STATUS = 3, S_CAUSE = 4,
                 S_EPC = 5, S_BAD = 6, S_TIMER = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exc;
    logic [31:0] pc;
    logic        dly;
    logic [31:0] bad;
    logic [5:0]  intr;
    logic [31:0] expRd;
    int          sel;
    logic [31:0] expOut;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[19];
  int   total = 0;
  int   passed = 0;

  function automatic logic [31:0] getOut(input int sel);
    case (sel)
      S_RD:      return bus.rdata_o;
      S_COUNT:   return bus.count_o;
      S_COMPARE: return bus.compare_o;
      S_STATUS:  return bus.status_o;
      S_CAUSE:   return bus.cause_o;
      S_EPC:     return bus.epc_o;
      S_BAD:     return bus.badvaddr_o;
      default:   return {31'd0, bus.timer_int_o};
    endcase
  endfunction

  task automatic expect1(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = getOut(e.sel);
      total++;
      if (act === e.exp) passed++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0; bus.raddr_i = '0;
    bus.int_i = '0; bus.excepttype_i = '0; bus.pc_i = '0; bus.in_delay_i = 1'b0; bus.badaddr_i = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d; bus.raddr_i = a;
  endtask

  task automatic checkResetState(input string tag);
    expect1({tag, "_count"}, S_COUNT, 32'h0);
    expect1({tag, "_compare"}, S_COMPARE, 32'h0);
    expect1({tag, "_status"}, S_STATUS, 32'h0040_0000);
    expect1({tag, "_cause"}, S_CAUSE, 32'h0);
    expect1({tag, "_epc"}, S_EPC, 32'h0);
    expect1({tag, "_badvaddr"}, S_BAD, 32'h0);
    expect1({tag, "_timer"}, S_TIMER, 32'h0);
    drain();
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic [4:0] raddr,
                              input logic [31:0] exc, input logic [31:0] pc, input logic dly,
                              input logic [31:0] bad, input logic [5:0] intr,
                              input logic [31:0] expRd, input int sel, input logic [31:0] expOut);
    vec_t v;
    v.name = name; v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr;
    v.exc = exc; v.pc = pc; v.dly = dly; v.bad = bad; v.intr = intr;
    v.expRd = expRd; v.sel = sel; v.expOut = expOut;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk("sys_delay",   0, 0,  0,            12, 32'h08, 32'hBFC0_0100, 1, 0, 0, 32'h0040_0000, S_EPC,    32'hBFC0_00FC);
    tbl[1]  = mk("sys_cause",   0, 0,  0,            13, 0,      0,             0, 0, 0, 32'h8000_0020, S_STATUS, 32'h0040_0002);
    tbl[2]  = mk("ri_nested",   0, 0,  0,            14, 32'h0a, 32'h200,       0, 0, 0, 32'hBFC0_00FC, S_EPC,    32'hBFC0_00FC);
    tbl[3]  = mk("ri_cause",    0, 0,  0,            13, 0,      0,             0, 0, 0, 32'h8000_0028, S_CAUSE,  32'h8000_0028);
    tbl[4]  = mk("eret1",       0, 0,  0,            12, 32'h0e, 0,             0, 0, 0, 32'h0040_0002, S_STATUS, 32'h0040_0000);
    tbl[5]  = mk("adel",        0, 0,  0,            13, 32'h04, 32'h300,       0, 32'h8000_0003, 0, 32'h8000_0028, S_BAD, 32'h8000_0003);
    tbl[6]  = mk("adel_cause",  0, 0,  0,            13, 0,      0,             0, 0, 0, 32'h0000_0010, S_EPC,    32'h0000_0300);
    tbl[7]  = mk("eret2",       0, 0,  0,            8,  32'h0e, 0,             0, 0, 0, 32'h8000_0003, S_STATUS, 32'h0040_0000);
    tbl[8]  = mk("bp_vs_mtc0",  1, 14, 32'h1234,     14, 32'h09, 32'h100,       0, 0, 0, 32'h0000_1234, S_EPC,    32'h0000_0100);
    tbl[9]  = mk("bp_cause",    0, 0,  0,            13, 0,      0,             0, 0, 0, 32'h0000_0024, S_STATUS, 32'h0040_0002);
    tbl[10] = mk("status_mask", 1, 12, 32'hFFFF_FFFF, 12, 0,     0,             0, 0, 0, 32'h0040_FF03, S_STATUS, 32'h0040_FF03);
    tbl[11] = mk("cause_mask",  1, 13, 32'hFFFF_FFFF, 13, 0,     0,             0, 0, 0, 32'h0000_0324, S_CAUSE,  32'h0000_0324);
    tbl[12] = mk("ov_vs_status",1, 12, 32'h0,        12, 32'h0c, 32'h400,       1, 0, 0, 32'h0040_0000, S_STATUS, 32'h0040_0002);
    tbl[13] = mk("ov_cause",    0, 0,  0,            13, 0,      0,             0, 0, 0, 32'h0000_0330, S_EPC,    32'h0000_0100);
    tbl[14] = mk("badv_ro",     1, 8,  32'hDEAD_BEEF, 8, 0,      0,             0, 0, 0, 32'h8000_0003, S_BAD,    32'h8000_0003);
    tbl[15] = mk("unmapped",    1, 5,  32'h1234_5678, 5, 0,      0,             0, 0, 0, 32'h0000_0000, S_EPC,    32'h0000_0100);
    tbl[16] = mk("hw_int",      0, 0,  0,            13, 0,      0,             0, 0, 6'h21, 32'h0000_0330, S_CAUSE, 32'h0000_8730);
    tbl[17] = mk("epc_write",   1, 14, 32'hCAFE_0000, 14, 0,     0,             0, 0, 0, 32'h0000_0000, S_EPC,    32'hCAFE_0000);
    tbl[18] = mk("int_clear",   0, 0,  0,            11, 0,      0,             0, 0, 0, 32'h0000_0000, S_CAUSE,  32'h0000_0330);
    // epc_write reads back through the bypass path, so its rdata is the written value.
    tbl[17].expRd = 32'hCAFE_0000;

    idle();
    #12;
    checkResetState("reset");
    rst = 1'b0;

    // Divide-by-2 Count and wrap.
    repeat (10) cyc();
    expect1("count_div2", S_COUNT, 32'd5); drain();
    mtc0(5'd9, 32'hFFFF_FFFF);
    #1;
    expect1("count_bypass", S_RD, 32'hFFFF_FFFF); drain();
    cyc();
    idle();
    expect1("count_written", S_COUNT, 32'hFFFF_FFFF); drain();
    cyc(); cyc();
    expect1("count_wrap", S_COUNT, 32'h0); drain();

    // Timer interrupt set and cleared by Compare write.
    mtc0(5'd11, 32'h10);
    cyc();
    idle();
    expect1("compare_wr", S_COMPARE, 32'h10); drain();
    for (int i = 0; i < 100 && !bus.timer_int_o; i++) cyc();
    if (!bus.timer_int_o) timeoutFail("timer_wait");
    expect1("timer_set", S_TIMER, 32'h1);
    expect1("timer_count", S_COUNT, 32'h10); drain();
    cyc();
    expect1("cause_ip7", S_CAUSE, 32'h0000_8000); drain();
    mtc0(5'd11, 32'h40);
    cyc();
    idle();
    expect1("timer_clear", S_TIMER, 32'h0);
    expect1("compare_40", S_COMPARE, 32'h40); drain();
    mtc0(5'd11, 32'h0);
    cyc();
    idle();
    cyc(); cyc();
    expect1("cause_ip7_clr", S_CAUSE, 32'h0); drain();

    foreach (tbl[k]) begin
      bus.we_i = tbl[k].we; bus.waddr_i = tbl[k].waddr; bus.wdata_i = tbl[k].wdata;
      bus.raddr_i = tbl[k].raddr; bus.excepttype_i = tbl[k].exc; bus.pc_i = tbl[k].pc;
      bus.in_delay_i = tbl[k].dly; bus.badaddr_i = tbl[k].bad; bus.int_i = tbl[k].intr;
      #1;
      expect1({tbl[k].name, "_rd"}, S_RD, tbl[k].expRd); drain();
      cyc();
      expect1({tbl[k].name, "_out"}, tbl[k].sel, tbl[k].expOut); drain();
    end
    idle();

    // Asynchronous reset in the middle of a cycle while Count is running.
    mtc0(5'd9, 32'h30);
    cyc();
    idle();
    for (int i = 0; i < 40 && bus.count_o != 32'h37; i++) cyc();
    if (bus.count_o != 32'h37) timeoutFail("count_37_wait");
    expect1("count_pre_rst", S_COUNT, 32'h37); drain();
    #2;
    rst = 1'b1;
    #1;
    checkResetState("async_rst");
    #1;
    rst = 1'b0;
    cyc();
    expect1("tick_rst_0", S_COUNT, 32'h0); drain();
    cyc();
    expect1("tick_rst_1", S_COUNT, 32'h1); drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
